// File: rtl/elevator_pkg.sv
// Constants shared by the elevator front-end and controller: floor count,
// default debounce interval and 7-segment digits for the floor display.
package elevator_pkg;

  localparam int N_FLOORS        = 4;
  localparam int FLOOR_W         = $clog2(N_FLOORS);
  localparam int DEBOUNCE_CYCLES = 500_000;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;

  typedef logic [N_FLOORS-1:0] floor_mask_t;

  function automatic logic [6:0] floor_to_seg(input logic [FLOOR_W-1:0] floor);
    logic [6:0] seg;
    case (floor)
      2'd0:    seg = SEG_0;
      2'd1:    seg = SEG_1;
      2'd2:    seg = SEG_2;
      2'd3:    seg = SEG_3;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button front end: 2-FF synchronizer followed by a stable-level
// debouncer that only follows the input after DEBOUNCE_CYCLES agreeing cycles.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = elevator_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             level_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Counter only runs while the synchronized input disagrees with the held level
  always_comb begin
    level_next = level_reg;
    cnt_next   = '0;
    if (sync2_reg != level_reg) begin
      if (cnt_reg == CNT_LAST) begin
        level_next = sync2_reg;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      level_reg <= level_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/floor_call_panel.sv
// Hall-call panel: debounced buttons latch pending calls that are held until
// the controller opens the door at that floor.
module floor_call_panel #(
  parameter  int N_FLOORS        = elevator_pkg::N_FLOORS,
  parameter  int DEBOUNCE_CYCLES = elevator_pkg::DEBOUNCE_CYCLES,
  localparam int FLOOR_W         = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_FLOORS-1:0] btn_raw,
  input  logic                door_open,
  input  logic [FLOOR_W-1:0]  current_floor,
  output logic [N_FLOORS-1:0] floor_request,
  output logic [FLOOR_W:0]    pending_count,
  output logic                accept_pulse
);

  logic [N_FLOORS-1:0] db;
  logic [N_FLOORS-1:0] db_d_reg;
  logic [N_FLOORS-1:0] press_reg;
  logic                door_d_reg;
  logic                service_reg;
  logic [FLOOR_W-1:0]  service_floor_reg;
  logic [N_FLOORS-1:0] floor_request_reg;
  logic [N_FLOORS-1:0] floor_request_next;
  logic [FLOOR_W:0]    pending_count_reg;
  logic [FLOOR_W:0]    pending_count_next;
  logic                accept_pulse_reg;
  logic                accept_pulse_next;
  logic [N_FLOORS-1:0] suppress_mask;
  logic [N_FLOORS-1:0] clear_mask;

  generate
    for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_btn
      button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (btn_raw[gi]),
        .level  (db[gi])
      );
    end
  endgenerate

  // Press and service edges are both registered so they line up one cycle later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_d_reg          <= '0;
      press_reg         <= '0;
      door_d_reg        <= 1'b0;
      service_reg       <= 1'b0;
      service_floor_reg <= '0;
    end else begin
      db_d_reg    <= db;
      press_reg   <= db & ~db_d_reg;
      door_d_reg  <= door_open;
      service_reg <= door_open & ~door_d_reg;
      if (door_open && !door_d_reg) begin
        service_floor_reg <= current_floor;
      end
    end
  end

  // Out-of-range floor numbers match no bit, so they suppress and clear nothing
  always_comb begin
    suppress_mask = '0;
    clear_mask    = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (door_open && (int'(current_floor) == i)) begin
        suppress_mask[i] = 1'b1;
      end
      if (service_reg && (int'(service_floor_reg) == i)) begin
        clear_mask[i] = 1'b1;
      end
    end
  end

  // Clear is applied last so it wins over a coincident set
  always_comb begin
    floor_request_next = (floor_request_reg | (press_reg & ~suppress_mask)) & ~clear_mask;
    pending_count_next = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      pending_count_next = pending_count_next + (FLOOR_W + 1)'(floor_request_next[i]);
    end
    accept_pulse_next = |(floor_request_next & ~floor_request_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      floor_request_reg <= '0;
      pending_count_reg <= '0;
      accept_pulse_reg  <= 1'b0;
    end else begin
      floor_request_reg <= floor_request_next;
      pending_count_reg <= pending_count_next;
      accept_pulse_reg  <= accept_pulse_next;
    end
  end

  assign floor_request = floor_request_reg;
  assign pending_count = pending_count_reg;
  assign accept_pulse  = accept_pulse_reg;

endmodule
